// File: rtl/plot_fb_writer.sv
// plot_fb_writer
//   Receives pixel plots from the shape drawers, discards off-screen pixels,
//   buffers the rest and writes them to the framebuffer port, which has a
//   ready handshake. Also fills the whole screen with one colour on request.
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   vga_x/vga_y/vga_colour/vga_plot plot input; one pixel per high strobe cycle
//   clear_start, clear_colour       full-screen clear request and fill colour
//   clear_done                      one-cycle pulse when the clear finishes
//   overflow                        sticky: an on-screen plot was dropped
//   mem_addr/mem_data/mem_we        framebuffer write request (registered)
//   mem_ready                       write accepted when mem_we && mem_ready
module plot_fb_writer #(
  parameter int WIDTH      = 160,
  parameter int HEIGHT     = 120,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        vga_x,
  input  logic [6:0]        vga_y,
  input  logic [2:0]        vga_colour,
  input  logic              vga_plot,
  input  logic              clear_start,
  input  logic [2:0]        clear_colour,
  output logic              clear_done,
  output logic              overflow,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [2:0]        mem_data,
  output logic              mem_we,
  input  logic              mem_ready
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = ADDR_W + 3;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t             r_state;
  logic [ADDR_W-1:0]  r_cnt;
  logic [2:0]         r_clr_colour;
  // Write that was stalled when a clear started; it is replayed after the clear.
  logic               r_sv;
  logic [ENT_W-1:0]   r_sv_ent;
  logic [ENT_W-1:0]   r_fifo [FIFO_DEPTH];
  logic [PTR_W:0]     r_wp;
  logic [PTR_W:0]     r_rp;
  logic               r_mem_we;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [2:0]         r_mem_data;
  logic               r_clear_done;
  logic               r_overflow;

  logic               w_in_ok;
  logic [ENT_W-1:0]   w_entry;
  logic               w_empty;
  logic               w_full;
  logic               w_done;
  logic               w_clr_go;
  logic               w_load;
  logic               w_pop;
  logic               w_byp;
  logic               w_push;
  logic               w_drop;

  // Capture decode, FIFO status and the output-slot refill decision.
  always_comb begin
    w_in_ok  = vga_plot && (32'(vga_x) < WIDTH) && (32'(vga_y) < HEIGHT);
    w_entry  = {ADDR_W'(32'(vga_y) * WIDTH + 32'(vga_x)), vga_colour};
    w_empty  = (r_wp == r_rp);
    w_full   = (r_wp[PTR_W] != r_rp[PTR_W]) &&
               (r_wp[PTR_W-1:0] == r_rp[PTR_W-1:0]);
    w_done   = r_mem_we && mem_ready;
    w_clr_go = (r_state == S_IDLE) && clear_start;
    // The output register acts as one extra buffer slot: it refills when it
    // is empty or its write completes, and on the final clear write.
    if (r_state == S_IDLE) begin
      w_load = !clear_start && (!r_mem_we || mem_ready);
    end else begin
      w_load = w_done && (r_cnt == LAST_ADDR);
    end
    w_pop  = w_load && !r_sv && !w_empty;
    // An empty FIFO lets a plot go straight to the output: one-cycle latency.
    w_byp  = w_load && !r_sv && w_empty && w_in_ok;
    w_push = w_in_ok && !w_byp && (!w_full || w_pop);
    w_drop = w_in_ok && !w_byp && w_full && !w_pop;
  end

  // FIFO storage; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wp[PTR_W-1:0]] <= w_entry;
    end
  end

  // Control FSM, FIFO pointers and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_clr_colour <= 3'd0;
      r_sv         <= 1'b0;
      r_sv_ent     <= '0;
      r_wp         <= '0;
      r_rp         <= '0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_data   <= 3'd0;
      r_clear_done <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_clear_done <= 1'b0;
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      if (w_clr_go)    r_overflow <= 1'b0;
      else if (w_drop) r_overflow <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (clear_start) begin
            r_state      <= S_CLEAR;
            r_cnt        <= '0;
            r_clr_colour <= clear_colour;
            r_mem_we     <= 1'b1;
            r_mem_addr   <= '0;
            r_mem_data   <= clear_colour;
            if (r_mem_we && !mem_ready) begin
              r_sv     <= 1'b1;
              r_sv_ent <= {r_mem_addr, r_mem_data};
            end
          end
        end
        S_CLEAR: begin
          if (w_done) begin
            if (r_cnt == LAST_ADDR) begin
              r_state      <= S_IDLE;
              r_clear_done <= 1'b1;
            end else begin
              r_cnt      <= r_cnt + 1'b1;
              r_mem_addr <= r_cnt + 1'b1;
              r_mem_data <= r_clr_colour;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // Refill of the output slot; takes priority over the clear-step update.
      if (w_load) begin
        if (r_sv) begin
          r_sv                     <= 1'b0;
          r_mem_we                 <= 1'b1;
          {r_mem_addr, r_mem_data} <= r_sv_ent;
        end else if (w_pop) begin
          r_mem_we                 <= 1'b1;
          {r_mem_addr, r_mem_data} <= r_fifo[r_rp[PTR_W-1:0]];
        end else if (w_byp) begin
          r_mem_we                 <= 1'b1;
          {r_mem_addr, r_mem_data} <= w_entry;
        end else begin
          r_mem_we <= 1'b0;
        end
      end
    end
  end

  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_data   = r_mem_data;
  assign clear_done = r_clear_done;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_plot_fb_writer.sv
// Directed testbench for plot_fb_writer with hand-computed expectations.
module tb_plot_fb_writer;

  logic        clk;
  logic        rst_n;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;
  logic        clear_start;
  logic [2:0]  clear_colour;
  logic        clear_done;
  logic        overflow;
  logic [14:0] mem_addr;
  logic [2:0]  mem_data;
  logic        mem_we;
  logic        mem_ready;

  int n_vec;
  int n_miss;

  plot_fb_writer dut (
    .clk(clk), .rst_n(rst_n),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
    .clear_start(clear_start), .clear_colour(clear_colour), .clear_done(clear_done),
    .overflow(overflow), .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
    .mem_ready(mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic plot(input int x, input int y, input int c);
    vga_x      = 8'(x);
    vga_y      = 7'(y);
    vga_colour = 3'(c);
    vga_plot   = 1'b1;
    step();
    vga_plot   = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  logic [31:0] exp_ent [5];
  int idx;
  int pulses;

  initial begin
    n_vec = 0; n_miss = 0;
    rst_n = 1'b1; vga_x = 8'd0; vga_y = 7'd0; vga_colour = 3'd0; vga_plot = 1'b0;
    clear_start = 1'b0; clear_colour = 3'd0; mem_ready = 1'b1;
    #2;
    do_reset();

    // 1: reset state and single plot latency
    check_vec("rst_we", 32'(mem_we), 32'd0);
    check_vec("rst_addr", 32'(mem_addr), 32'd0);
    check_vec("rst_data", 32'(mem_data), 32'd0);
    check_vec("rst_done", 32'(clear_done), 32'd0);
    check_vec("rst_ovf", 32'(overflow), 32'd0);
    plot(10, 5, 3);
    check_vec("t1_we", 32'(mem_we), 32'd1);
    check_vec("t1_addr", 32'(mem_addr), 32'd810);
    check_vec("t1_data", 32'(mem_data), 32'd3);
    step();
    check_vec("t1_we_off", 32'(mem_we), 32'd0);

    // 2: five buffered, sixth dropped, drained in order
    mem_ready = 1'b0;
    for (int k = 0; k < 6; k++) plot(k + 1, k, (k + 1) % 8);
    check_vec("t2_ovf", 32'(overflow), 32'd1);
    mem_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check_vec("t2_we", 32'(mem_we), 32'd1);
      check_vec("t2_ent", {14'd0, mem_addr, mem_data}, 32'(((161 * k + 1) << 3) | ((k + 1) % 8)));
      step();
    end
    check_vec("t2_we_end", 32'(mem_we), 32'd0);

    // 3: out-of-range plots and the last visible pixel
    do_reset();
    plot(160, 0, 1);
    check_vec("t3_x_oob", 32'(mem_we), 32'd0);
    plot(0, 120, 1);
    check_vec("t3_y_oob", 32'(mem_we), 32'd0);
    check_vec("t3_ovf", 32'(overflow), 32'd0);
    plot(159, 119, 6);
    check_vec("t3_we", 32'(mem_we), 32'd1);
    check_vec("t3_addr", 32'(mem_addr), 32'd19199);
    check_vec("t3_data", 32'(mem_data), 32'd6);
    step();

    // 4: full-screen clear with a plot mid-clear; overflow cleared on entry
    mem_ready = 1'b0;
    for (int k = 0; k < 6; k++) plot(k, 0, 1);
    mem_ready = 1'b1;
    for (int k = 0; k < 5; k++) step();
    check_vec("t4_ovf_set", 32'(overflow), 32'd1);
    check_vec("t4_idle_we", 32'(mem_we), 32'd0);
    clear_start = 1'b1; clear_colour = 3'd2;
    step();
    clear_start = 1'b0; clear_colour = 3'd0;
    check_vec("t4_ovf_clr", 32'(overflow), 32'd0);
    pulses = 0;
    for (int k = 0; k < 19200; k++) begin
      if (mem_we !== 1'b1 || {mem_addr, mem_data} !== 18'((k << 3) | 2))
        check_vec("t4_clr_ent", {13'd0, mem_we, mem_addr, mem_data}, 32'((1 << 18) | (k << 3) | 2));
      if (clear_done) pulses++;
      if (k == 100) begin
        vga_x = 8'd1; vga_y = 7'd1; vga_colour = 3'd7; vga_plot = 1'b1;
      end
      step();
      vga_plot = 1'b0;
    end
    check_vec("t4_clr_words", 32'(pulses), 32'd0);
    check_vec("t4_done", 32'(clear_done), 32'd1);
    check_vec("t4_post_we", 32'(mem_we), 32'd1);
    check_vec("t4_post_addr", 32'(mem_addr), 32'd161);
    check_vec("t4_post_data", 32'(mem_data), 32'd7);
    step();
    check_vec("t4_done_once", 32'(clear_done), 32'd0);
    check_vec("t4_we_end", 32'(mem_we), 32'd0);

    // 5: random ready during drain
    do_reset();
    mem_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      plot(3 * k, 2 * k + 1, k + 2);
      exp_ent[k] = 32'((((2 * k + 1) * 160 + 3 * k) << 3) | ((k + 2) % 8));
    end
    idx = 0;
    for (int c = 0; c < 300 && idx < 5; c++) begin
      mem_ready = 1'($urandom_range(0, 1));
      check_vec("t5_we", 32'(mem_we), 32'd1);
      check_vec("t5_ent", {14'd0, mem_addr, mem_data}, exp_ent[idx]);
      if (mem_ready) idx++;
      step();
    end
    check_vec("t5_count", 32'(idx), 32'd5);
    check_vec("t5_we_end", 32'(mem_we), 32'd0);

    // 6: asynchronous reset mid-clear
    mem_ready = 1'b1;
    clear_start = 1'b1; clear_colour = 3'd5;
    step();
    clear_start = 1'b0;
    for (int k = 0; k < 50; k++) step();
    check_vec("t6_mid_we", 32'(mem_we), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check_vec("t6_async_we", 32'(mem_we), 32'd0);
    step();
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 30; k++) begin
      if (clear_done || mem_we) pulses++;
      step();
    end
    check_vec("t6_quiet", 32'(pulses), 32'd0);
    plot(2, 3, 1);
    check_vec("t6_idle_we", 32'(mem_we), 32'd1);
    check_vec("t6_idle_addr", 32'(mem_addr), 32'd482);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
